vending_machine_change: RTL and testbench
=========================================

VENDING_MACHINE_CHANGE -- requirements
Module: vending_machine_change

Interface
REQ-001 Parameter PRICE, default 100, item price in cents; SHALL be a positive multiple of 5.
REQ-002 Parameter CREDIT_W, default $clog2(PRICE+40)+1, width of the credit register.
REQ-003 clk  input  1  single system clock; all state SHALL change on posedge clk only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 nickel / dime / quarter  input  1 each  coin-present strobes, 5/10/25 cents; any combination SHALL be legal in one cycle.
REQ-006 cancel  input  1  refund request.
REQ-007 valid  output  1  vend pulse, one cycle per item.
REQ-008 change_nickel / change_dime / change_quarter  output  1 each  coin-return pulses; at most one is high per cycle.
REQ-009 coin_reject  output  1  pulse meaning coins presented this cycle were not credited and are physically returned.
REQ-010 credit  output  CREDIT_W  current held credit in cents.
REQ-011 busy  output  1  high while in VEND or CHANGE.

Function
REQ-012 FSM states SHALL be COLLECT, VEND and CHANGE; all outputs SHALL be registered.
REQ-013 COLLECT: sum = 5*nickel + 10*dime + 25*quarter; if credit+sum < PRICE, credit <= credit+sum and state stays COLLECT.
REQ-014 COLLECT: if credit+sum >= PRICE, credit <= credit+sum-PRICE and next state is VEND; an overshoot of up to 35 cents SHALL never be eaten.
REQ-015 VEND SHALL last exactly one cycle with valid=1; next state is CHANGE if credit>0, else COLLECT.
REQ-016 CHANGE: each cycle greedy-return one coin: credit>=25 -> change_quarter, credit-=25; else credit>=10 -> change_dime, credit-=10; else change_nickel, credit-=5.
REQ-017 CHANGE SHALL return to COLLECT in the cycle after the pulse that brings credit to 0.
REQ-018 cancel in COLLECT with credit>0 SHALL take priority over coins: coins that cycle rejected, next state CHANGE (full credit refunded).
REQ-019 cancel in COLLECT with credit=0 SHALL have no effect besides rejecting coin(s) presented the same cycle; cancel in VEND/CHANGE SHALL be ignored.
REQ-020 Any coin presented in VEND or CHANGE SHALL assert coin_reject for one cycle; credit SHALL not change due to it.
REQ-021 Latency: the coin reaching PRICE at edge N SHALL yield valid=1 in cycle N+1; the first change pulse in cycle N+2.
REQ-022 credit SHALL never wrap; CREDIT_W SHALL hold PRICE+35.

Reset
REQ-023 reset=1 at posedge clk SHALL force state COLLECT, credit=0, valid, change_*, coin_reject, busy all 0, from any state.
REQ-024 Reset mid-CHANGE SHALL abandon the remaining refund (no further change pulses).
REQ-025 Coins presented in a cycle where reset=1 SHALL be neither credited nor rejected.

Structure
REQ-026 A shared package vending_pkg SHALL hold the state enum (COLLECT, VEND, CHANGE) and coin value constants NICKEL_C=5, DIME_C=10, QUARTER_C=25.
REQ-027 One sub-module, coin_adder (combinational: three strobes -> cents sum), is natural; everything else in vending_machine_change.

Verification (PRICE=100 unless stated)
REQ-028 Reset, then quarter x4 on consecutive cycles -> valid=1 one cycle after 4th edge, no change pulses, credit=0.
REQ-029 Build 95 (quarter+dime+nickel x2 =80, then dime, nickel), then all three coins one cycle -> valid, then change_quarter, change_dime, credit 0, back to COLLECT.
REQ-030 Insert 65 cents, assert cancel -> change_quarter, change_quarter, change_dime, change_nickel, no valid.
REQ-031 Dime presented during CHANGE -> coin_reject=1 that cycle, refund sequence unaffected.
REQ-032 Assert reset during second change pulse -> all outputs 0 next cycle, credit=0, no further pulses.
REQ-033 PRICE=35 instance: quarter+dime+nickel in one cycle -> valid, then change_nickel, credit 0.

Source files
------------

// File: rtl/vending_machine_change_pkg.sv
// vending_pkg: shared FSM state type and coin values for the vending machine
package vending_pkg;
    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_e;
    localparam int NICKEL_C  = 5;
    localparam int DIME_C    = 10;
    localparam int QUARTER_C = 25;
endpackage

// File: rtl/vending_machine_change_coin_adder.sv
// coin_adder: combinational cents total of the coin strobes seen in one cycle
module coin_adder
    import vending_pkg::*;
(
    input  logic       nickel_i,
    input  logic       dime_i,
    input  logic       quarter_i,
    output logic [5:0] sum_o
);
    assign sum_o = (nickel_i ? 6'(NICKEL_C) : 6'd0) + (dime_i ? 6'(DIME_C) : 6'd0) + (quarter_i ? 6'(QUARTER_C) : 6'd0);
endmodule

// File: rtl/vending_machine_change.sv
// vending_machine_change: coin collection, vend pulse and greedy change return
module vending_machine_change
    import vending_pkg::*;
#(
    parameter int PRICE    = 100,
    parameter int CREDIT_W = $clog2(PRICE + 40) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    output logic                valid,
    output logic                change_nickel,
    output logic                change_dime,
    output logic                change_quarter,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);
    localparam logic [CREDIT_W-1:0] PRICE_W   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_W  = CREDIT_W'(NICKEL_C);
    localparam logic [CREDIT_W-1:0] DIME_W    = CREDIT_W'(DIME_C);
    localparam logic [CREDIT_W-1:0] QUARTER_W = CREDIT_W'(QUARTER_C);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, total, ret_val;
    logic [5:0]          coin_sum;
    logic                any_coin, give_q, give_d, give_n;
    logic                valid_q, valid_d, cq_q, cq_d, cd_q, cd_d, cn_q, cn_d, rej_q, rej_d, busy_q;

    coin_adder u_coin_adder (
        .nickel_i (nickel),
        .dime_i   (dime),
        .quarter_i(quarter),
        .sum_o    (coin_sum)
    );

    assign any_coin = nickel | dime | quarter;
    assign total    = credit_q + CREDIT_W'(coin_sum);
    // Greedy pick from the current credit; only applied when credit is non-zero,
    // and credit is always a multiple of 5, so the nickel branch never underflows.
    assign give_q   = credit_q >= QUARTER_W;
    assign give_d   = !give_q && credit_q >= DIME_W;
    assign give_n   = !give_q && !give_d;
    assign ret_val  = give_q ? QUARTER_W : give_d ? DIME_W : NICKEL_W;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        valid_d  = 1'b0;
        cq_d     = 1'b0;
        cd_d     = 1'b0;
        cn_d     = 1'b0;
        rej_d    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (cancel) begin
                    rej_d = any_coin;
                    if (credit_q != '0) begin
                        state_d  = CHANGE;
                        credit_d = credit_q - ret_val;
                        {cq_d, cd_d, cn_d} = {give_q, give_d, give_n};
                    end
                end else if (total >= PRICE_W) begin
                    state_d  = VEND;
                    credit_d = total - PRICE_W;
                    valid_d  = 1'b1;
                end else begin
                    credit_d = total;
                end
            end
            VEND, CHANGE: begin
                rej_d = any_coin;
                if (credit_q != '0) begin
                    state_d  = CHANGE;
                    credit_d = credit_q - ret_val;
                    {cq_d, cd_d, cn_d} = {give_q, give_d, give_n};
                end else begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= COLLECT;
            credit_q <= '0;
            valid_q  <= 1'b0;
            cq_q     <= 1'b0;
            cd_q     <= 1'b0;
            cn_q     <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            valid_q  <= valid_d;
            cq_q     <= cq_d;
            cd_q     <= cd_d;
            cn_q     <= cn_d;
            rej_q    <= rej_d;
            busy_q   <= state_d != COLLECT;
        end
    end

    assign valid          = valid_q;
    assign change_quarter = cq_q;
    assign change_dime    = cd_q;
    assign change_nickel  = cn_q;
    assign coin_reject    = rej_q;
    assign credit         = credit_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_vending_machine_change.sv
// tb_vending_machine_change: directed checks of vend, change, cancel, reject and reset
module tb_vending_machine_change;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, nickel = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0;
    logic       valid, cn, cd, cq, rej, busy;
    logic [8:0] credit;
    logic       reset2 = 1'b1, n2 = 1'b0, d2 = 1'b0, q2 = 1'b0, c2 = 1'b0;
    logic       valid2, cn2, cd2, cq2, rej2, busy2;
    logic [7:0] credit2;
    int vecs = 0;
    int errs = 0;

    vending_machine_change #(.PRICE(100)) dut (
        .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter), .cancel(cancel),
        .valid(valid), .change_nickel(cn), .change_dime(cd), .change_quarter(cq),
        .coin_reject(rej), .credit(credit), .busy(busy)
    );

    vending_machine_change #(.PRICE(35)) dut35 (
        .clk(clk), .reset(reset2), .nickel(n2), .dime(d2), .quarter(q2), .cancel(c2),
        .valid(valid2), .change_nickel(cn2), .change_dime(cd2), .change_quarter(cq2),
        .coin_reject(rej2), .credit(credit2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic n, input logic d, input logic q, input logic c);
        reset = r; nickel = n; dime = d; quarter = q; cancel = c;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input logic r, input logic n, input logic d, input logic q);
        reset2 = r; n2 = n; d2 = d; q2 = q;
        @(posedge clk);
        #1;
    endtask

    // out order: {valid, change_quarter, change_dime, change_nickel, coin_reject, busy}
    task automatic exp_out(input string tag, input logic [5:0] o, input int cr);
        chk({tag, "/out"}, {26'd0, valid, cq, cd, cn, rej, busy}, {26'd0, o});
        chk({tag, "/credit"}, {23'd0, credit}, cr);
    endtask

    task automatic exp_out2(input string tag, input logic [5:0] o, input int cr);
        chk({tag, "/out"}, {26'd0, valid2, cq2, cd2, cn2, rej2, busy2}, {26'd0, o});
        chk({tag, "/credit"}, {24'd0, credit2}, cr);
    endtask

    initial begin
        // reset, then exact price with four quarters
        cyc(1, 0, 0, 0, 0); exp_out("reset", 6'b000000, 0);
        cyc(0, 0, 0, 1, 0); exp_out("q1", 6'b000000, 25);
        cyc(0, 0, 0, 1, 0); exp_out("q2", 6'b000000, 50);
        cyc(0, 0, 0, 1, 0); exp_out("q3", 6'b000000, 75);
        cyc(0, 0, 0, 1, 0); exp_out("q4_vend", 6'b100001, 0);
        cyc(0, 0, 0, 0, 0); exp_out("q4_idle", 6'b000000, 0);
        // overshoot 35 returned as quarter + dime, nickel in VEND rejected
        cyc(0, 1, 1, 1, 0); exp_out("all_40", 6'b000000, 40);
        cyc(0, 1, 1, 1, 0); exp_out("all_80", 6'b000000, 80);
        cyc(0, 0, 1, 0, 0); exp_out("d_90", 6'b000000, 90);
        cyc(0, 1, 0, 0, 0); exp_out("n_95", 6'b000000, 95);
        cyc(0, 1, 1, 1, 0); exp_out("over_vend", 6'b100001, 35);
        cyc(0, 1, 0, 0, 0); exp_out("over_cq_rej", 6'b010011, 10);
        cyc(0, 0, 0, 0, 0); exp_out("over_cd", 6'b001001, 0);
        cyc(0, 0, 0, 0, 0); exp_out("over_done", 6'b000000, 0);
        // cancel 65 with a dime rejected mid-refund
        cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0); exp_out("c65_build", 6'b000000, 65);
        cyc(0, 0, 0, 0, 1); exp_out("c65_cq1", 6'b010001, 40);
        cyc(0, 0, 1, 0, 0); exp_out("c65_cq2_rej", 6'b010011, 15);
        cyc(0, 0, 0, 0, 0); exp_out("c65_cd", 6'b001001, 5);
        cyc(0, 0, 0, 0, 0); exp_out("c65_cn", 6'b000101, 0);
        cyc(0, 0, 0, 0, 0); exp_out("c65_done", 6'b000000, 0);
        // cancel at zero credit rejects only the coin; cancel beats coins otherwise
        cyc(0, 0, 0, 1, 1); exp_out("cancel0_rej", 6'b000010, 0);
        cyc(0, 0, 0, 0, 0); exp_out("cancel0_idle", 6'b000000, 0);
        cyc(0, 0, 1, 0, 0); exp_out("d_10", 6'b000000, 10);
        cyc(0, 0, 0, 1, 1); exp_out("cancel_pri", 6'b001011, 0);
        cyc(0, 0, 0, 0, 0); exp_out("cancel_pri_done", 6'b000000, 0);
        // reset during second change pulse; coin with reset ignored
        cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 0, 0); cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1); exp_out("rst_cq1", 6'b010001, 40);
        cyc(0, 0, 0, 0, 0); exp_out("rst_cq2", 6'b010001, 15);
        cyc(1, 0, 0, 1, 0); exp_out("rst_hit", 6'b000000, 0);
        cyc(0, 0, 0, 0, 0); exp_out("rst_after1", 6'b000000, 0);
        cyc(0, 0, 0, 0, 0); exp_out("rst_after2", 6'b000000, 0);
        // PRICE=35 instance
        cyc2(1, 0, 0, 0); exp_out2("p35_reset", 6'b000000, 0);
        cyc2(0, 1, 1, 1); exp_out2("p35_vend", 6'b100001, 5);
        cyc2(0, 0, 0, 0); exp_out2("p35_cn", 6'b000101, 0);
        cyc2(0, 0, 0, 0); exp_out2("p35_done", 6'b000000, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
